// File: rtl/apb_uart_fifo.sv
// APB-attached UART with TX/RX FIFOs, programmable 16x prescaler, parity,
// 1/2 stop bits and a level interrupt request.
//
// Ports:
//   pclk, preset          - clock and synchronous active-high reset
//   paddr..pwdata         - APB slave request (8-bit address, 8-bit data)
//   pready, prdata,
//   pslverr               - APB slave response (zero wait states)
//   irqreq                - registered interrupt request
//   rxd                   - serial input, asynchronous to pclk
//   txd                   - serial output, idles high
module apb_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic [7:0] paddr,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] pwdata,
  output logic       pready,
  output logic [7:0] prdata,
  output logic       pslverr,
  output logic       irqreq,
  input  logic       rxd,
  output logic       txd
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  localparam logic [7:0] AddrData    = 8'h00;
  localparam logic [7:0] AddrStatus  = 8'h04;
  localparam logic [7:0] AddrCtrl    = 8'h08;
  localparam logic [7:0] AddrDivl    = 8'h0C;
  localparam logic [7:0] AddrDivh    = 8'h10;
  localparam logic [7:0] AddrIrqEn   = 8'h14;
  localparam logic [7:0] AddrIrqStat = 8'h18;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

  // Configuration and status registers
  logic [4:0]  ctrl_q;
  logic [15:0] div_q, div_act_q, pre_cnt_q;
  logic [4:0]  irq_en_q;
  logic        perr_q, ferr_q, ovr_q, irqreq_q;
  logic        tick16;

  // FIFOs
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic [7:0]    tx_head, rx_head;

  // TX engine
  uart_state_e tx_state_q;
  logic [3:0]  tx_tcnt_q;
  logic [2:0]  tx_bcnt_q;
  logic [7:0]  tx_shift_q;
  logic        tx_par_en_q, tx_par_bit_q, tx_two_q, txd_q;
  logic        tx_stop_done;

  // RX engine
  uart_state_e rx_state_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0]  rx_tcnt_q;
  logic [2:0]  rx_bcnt_q;
  logic [7:0]  rx_shift_q, rx_data_q;
  logic        rx_perr_q, rx_push_q, rx_perr_ev_q, rx_ferr_ev_q;

  // APB decode
  logic access, addr_hit, apb_err, wr_en, rd_en;
  logic sel_data, sel_status, sel_ctrl, sel_divl, sel_divh, sel_irq_en, sel_irq_stat;
  logic par_en, par_odd;
  logic [4:0] irq_stat;
  logic [7:0] status;

  always_comb begin
    sel_data     = 1'b0;
    sel_status   = 1'b0;
    sel_ctrl     = 1'b0;
    sel_divl     = 1'b0;
    sel_divh     = 1'b0;
    sel_irq_en   = 1'b0;
    sel_irq_stat = 1'b0;
    addr_hit     = 1'b1;
    case (paddr)
      AddrData:    sel_data     = 1'b1;
      AddrStatus:  sel_status   = 1'b1;
      AddrCtrl:    sel_ctrl     = 1'b1;
      AddrDivl:    sel_divl     = 1'b1;
      AddrDivh:    sel_divh     = 1'b1;
      AddrIrqEn:   sel_irq_en   = 1'b1;
      AddrIrqStat: sel_irq_stat = 1'b1;
      default:     addr_hit     = 1'b0;
    endcase
  end

  assign access  = psel & penable;
  assign apb_err = access & (~addr_hit | (pwrite & sel_status) | (pwrite & sel_data & tx_full)
                             | (~pwrite & sel_data & rx_empty));
  assign wr_en   = access & pwrite & ~apb_err;
  assign rd_en   = access & ~pwrite & ~apb_err;
  assign pready  = 1'b1;
  assign pslverr = apb_err;

  // Parity mode 11 behaves as "none"
  assign par_en  = ctrl_q[2] ^ ctrl_q[3];
  assign par_odd = ctrl_q[3] & ~ctrl_q[2];

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rp_q];
  assign rx_head  = rx_mem_q[rx_rp_q];

  assign status   = {3'b000, (tx_state_q != StIdle), rx_full, rx_empty, tx_full, tx_empty};
  assign irq_stat = {ovr_q, ferr_q, perr_q, tx_empty, ~rx_empty};

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (paddr)
        AddrData:    prdata = rx_head;
        AddrStatus:  prdata = status;
        AddrCtrl:    prdata = {3'b000, ctrl_q};
        AddrDivl:    prdata = div_q[7:0];
        AddrDivh:    prdata = div_q[15:8];
        AddrIrqEn:   prdata = {3'b000, irq_en_q};
        AddrIrqStat: prdata = {3'b000, irq_stat};
        default:     prdata = '0;
      endcase
    end
  end

  assign tx_push  = wr_en & sel_data;
  assign tx_flush = wr_en & sel_ctrl & pwdata[5];
  assign rx_pop   = rd_en & sel_data;
  assign rx_flush = wr_en & sel_ctrl & pwdata[6];
  // A pop in the same cycle frees the slot for the incoming byte
  assign rx_push  = rx_push_q & (~rx_full | rx_pop) & ~rx_flush;

  // Registers, sticky flags, interrupt and prescaler
  assign tick16 = (pre_cnt_q == div_act_q);

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q    <= 5'b00011;
      div_q     <= DIV_RESET;
      div_act_q <= DIV_RESET;
      pre_cnt_q <= '0;
      irq_en_q  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      irqreq_q  <= 1'b0;
    end else begin
      if (wr_en && sel_ctrl)   ctrl_q       <= pwdata[4:0];
      if (wr_en && sel_divl)   div_q[7:0]   <= pwdata;
      if (wr_en && sel_divh)   div_q[15:8]  <= pwdata;
      if (wr_en && sel_irq_en) irq_en_q     <= pwdata[4:0];
      // Divisor changes only take effect at a reload so the current tick period stays clean
      if (tick16) begin
        pre_cnt_q <= '0;
        div_act_q <= div_q;
      end else begin
        pre_cnt_q <= pre_cnt_q + 16'd1;
      end
      // Set wins over write-1-to-clear
      perr_q   <= (perr_q & ~(wr_en & sel_irq_stat & pwdata[2])) | (rx_push_q & rx_perr_ev_q);
      ferr_q   <= (ferr_q & ~(wr_en & sel_irq_stat & pwdata[3])) | (rx_push_q & rx_ferr_ev_q);
      ovr_q    <= (ovr_q & ~(wr_en & sel_irq_stat & pwdata[4]))
                  | (rx_push_q & rx_full & ~rx_pop & ~rx_flush);
      irqreq_q <= |(irq_stat & irq_en_q);
    end
  end

  assign irqreq = irqreq_q;

  // FIFO storage (no reset needed; occupancy is tracked by the counters)
  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= pwdata;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_q;
  end

  always_ff @(posedge pclk) begin
    if (preset || tx_flush) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || rx_flush) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // TX: pop either from idle or straight out of the last stop bit (no idle gap)
  assign tx_stop_done = (tx_state_q == StStop) & tick16 & (tx_tcnt_q == 4'd15)
                        & (tx_bcnt_q[0] == tx_two_q);
  assign tx_pop = ctrl_q[0] & ~tx_empty & ((tx_state_q == StIdle & tick16) | tx_stop_done);

  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_state_q   <= StIdle;
      tx_tcnt_q    <= '0;
      tx_bcnt_q    <= '0;
      tx_shift_q   <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_two_q     <= 1'b0;
      txd_q        <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q   <= StStart;
      tx_tcnt_q    <= '0;
      tx_shift_q   <= tx_head;
      tx_par_en_q  <= par_en;
      tx_par_bit_q <= (^tx_head) ^ par_odd;
      tx_two_q     <= ctrl_q[4];
      txd_q        <= 1'b0;
    end else if (tick16) begin
      tx_tcnt_q <= tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            tx_bcnt_q  <= '0;
            txd_q      <= tx_shift_q[0];
          end
          StData: begin
            if (tx_bcnt_q == 3'd7) begin
              tx_bcnt_q <= '0;
              if (tx_par_en_q) begin
                tx_state_q <= StParity;
                txd_q      <= tx_par_bit_q;
              end else begin
                tx_state_q <= StStop;
                txd_q      <= 1'b1;
              end
            end else begin
              tx_bcnt_q  <= tx_bcnt_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end
          StParity: begin
            tx_state_q <= StStop;
            tx_bcnt_q  <= '0;
            txd_q      <= 1'b1;
          end
          StStop: begin
            // bcnt counts stop bits already sent
            if (tx_bcnt_q[0] == tx_two_q) tx_state_q <= StIdle;
            else                          tx_bcnt_q  <= tx_bcnt_q + 3'd1;
            txd_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign txd = txd_q;

  // RX: start is validated at the 8th tick, then every bit is sampled 16 ticks later
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= StIdle;
      rx_tcnt_q    <= '0;
      rx_bcnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_perr_q    <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_perr_ev_q <= 1'b0;
      rx_ferr_ev_q <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= 1'b0;
      if (!ctrl_q[1]) begin
        rx_state_q <= StIdle;
      end else begin
        if (rx_state_q != StIdle && tick16) rx_tcnt_q <= rx_tcnt_q + 4'd1;
        case (rx_state_q)
          StIdle: begin
            if (rx_prev_q && !rx_s2_q) begin
              rx_state_q <= StStart;
              rx_tcnt_q  <= '0;
            end
          end
          StStart: begin
            if (tick16 && rx_tcnt_q == 4'd7) begin
              if (rx_s2_q) begin
                rx_state_q <= StIdle;
              end else begin
                rx_state_q <= StData;
                rx_tcnt_q  <= '0;
                rx_bcnt_q  <= '0;
                rx_perr_q  <= 1'b0;
              end
            end
          end
          StData: begin
            if (tick16 && rx_tcnt_q == 4'd15) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
              rx_bcnt_q  <= rx_bcnt_q + 3'd1;
              if (rx_bcnt_q == 3'd7) rx_state_q <= par_en ? StParity : StStop;
            end
          end
          StParity: begin
            if (tick16 && rx_tcnt_q == 4'd15) begin
              rx_perr_q  <= rx_s2_q != ((^rx_shift_q) ^ par_odd);
              rx_state_q <= StStop;
            end
          end
          StStop: begin
            if (tick16 && rx_tcnt_q == 4'd15) begin
              rx_push_q    <= 1'b1;
              rx_data_q    <= rx_shift_q;
              rx_perr_ev_q <= rx_perr_q;
              rx_ferr_ev_q <= ~rx_s2_q;
              rx_state_q   <= StIdle;
            end
          end
          default: rx_state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo (FIFO_DEPTH=4, divisor set to 0).
module tb_apb_uart_fifo;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [7:0] paddr = '0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] pwdata = '0;
  logic       pready, pslverr, irqreq, rxd, txd;
  logic [7:0] prdata;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 pclk = ~pclk;

  apb_uart_fifo #(
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd26)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr),
    .irqreq (irqreq),
    .rxd    (rxd),
    .txd    (txd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input logic err,
                           input string tag);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1; #1;
    check({tag, "_err"}, 16'(pslverr), 16'(err));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [7:0] exp, input logic err,
                          input string tag);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1; #1;
    check({tag, "_err"}, 16'(pslverr), 16'(err));
    check({tag, "_data"}, 16'(prdata), 16'(exp));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One frame at 16 cycles per bit (divisor 0), followed by one idle bit
  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic pbit,
                            input logic stopb);
    rxd_drv = 1'b0; wait_cyc(16);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i]; wait_cyc(16);
    end
    if (has_par) begin
      rxd_drv = pbit; wait_cyc(16);
    end
    rxd_drv = stopb; wait_cyc(16);
    rxd_drv = 1'b1; wait_cyc(16);
  endtask

  task automatic wait_txd_low(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      wait_cyc(1);
      if (txd == 1'b0) found = 1;
    end
    check({tag, "_start_seen"}, 16'(found), 16'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame_a5;
    frame_a5 = 10'b1_1010_0101_0;  // stop, data MSB..LSB, start

    // Reset values
    wait_cyc(3);
    check("rst_txd", 16'(txd), 16'd1);
    check("rst_irq", 16'(irqreq), 16'd0);
    check("rst_pready", 16'(pready), 16'd1);
    check("rst_pslverr", 16'(pslverr), 16'd0);
    check("rst_prdata", 16'(prdata), 16'd0);
    preset = 1'b0;
    wait_cyc(1);
    apb_read(8'h04, 8'h05, 1'b0, "rst_status");
    apb_read(8'h08, 8'h03, 1'b0, "rst_ctrl");
    apb_read(8'h0C, 8'h1A, 1'b0, "rst_divl");
    apb_read(8'h10, 8'h00, 1'b0, "rst_divh");
    apb_read(8'h14, 8'h00, 1'b0, "rst_irqen");

    // Divisor 0: one tick per cycle once the running period reloads
    apb_write(8'h0C, 8'h00, 1'b0, "divl_wr");
    apb_read(8'h0C, 8'h00, 1'b0, "divl_rd");
    wait_cyc(40);

    // TX waveform of 0xA5, 8N1: each bit exactly 16 cycles
    apb_write(8'h00, 8'hA5, 1'b0, "tx_a5_wr");
    wait_txd_low("tx_a5");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_a5_bit%0d_first", i), 16'(txd), 16'(frame_a5[i]));
      wait_cyc(15);
      check($sformatf("tx_a5_bit%0d_last", i), 16'(txd), 16'(frame_a5[i]));
      wait_cyc(1);
    end
    check("tx_a5_idle", 16'(txd), 16'd1);
    apb_read(8'h04, 8'h05, 1'b0, "tx_a5_status");

    // Loopback with even parity
    apb_write(8'h08, 8'h07, 1'b0, "lb_ctrl");
    loop_en = 1'b1;
    apb_write(8'h00, 8'h00, 1'b0, "lb_wr0");
    apb_write(8'h00, 8'hFF, 1'b0, "lb_wr1");
    apb_write(8'h00, 8'h3C, 1'b0, "lb_wr2");
    wait_cyc(700);
    apb_read(8'h04, 8'h01, 1'b0, "lb_status");
    apb_read(8'h00, 8'h00, 1'b0, "lb_rd0");
    apb_read(8'h00, 8'hFF, 1'b0, "lb_rd1");
    apb_read(8'h00, 8'h3C, 1'b0, "lb_rd2");
    apb_read(8'h18, 8'h02, 1'b0, "lb_irqstat");
    loop_en = 1'b0;

    // TX FIFO full (TX_EN=0) and RX overrun
    apb_write(8'h08, 8'h02, 1'b0, "ovr_ctrl");
    apb_write(8'h00, 8'h01, 1'b0, "txf_wr1");
    apb_write(8'h00, 8'h02, 1'b0, "txf_wr2");
    apb_write(8'h00, 8'h03, 1'b0, "txf_wr3");
    apb_write(8'h00, 8'h04, 1'b0, "txf_wr4");
    apb_write(8'h00, 8'h05, 1'b1, "txf_wr5");
    apb_read(8'h04, 8'h06, 1'b0, "txf_status");
    apb_write(8'h14, 8'h10, 1'b0, "ovr_irqen");
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    check("ovr_irq_before", 16'(irqreq), 16'd0);
    apb_read(8'h04, 8'h0A, 1'b0, "rxf_status");
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check("ovr_irq_after", 16'(irqreq), 16'd1);
    apb_read(8'h18, 8'h11, 1'b0, "ovr_irqstat");
    apb_read(8'h00, 8'h11, 1'b0, "ovr_rd_head");
    apb_write(8'h18, 8'h10, 1'b0, "ovr_clr");
    apb_write(8'h08, 8'h62, 1'b0, "flush_wr");
    apb_read(8'h08, 8'h02, 1'b0, "flush_ctrl");
    apb_read(8'h04, 8'h05, 1'b0, "flush_status");
    wait_cyc(2);
    check("ovr_irq_cleared", 16'(irqreq), 16'd0);

    // Framing error then parity error (even parity)
    apb_write(8'h14, 8'h0C, 1'b0, "err_irqen");
    apb_write(8'h08, 8'h06, 1'b0, "err_ctrl");
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    apb_read(8'h18, 8'h0B, 1'b0, "ferr_irqstat");
    check("ferr_irq", 16'(irqreq), 16'd1);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    apb_read(8'h18, 8'h0F, 1'b0, "perr_irqstat");
    apb_write(8'h18, 8'h0C, 1'b0, "err_clr");
    wait_cyc(1);
    check("err_irq_drop", 16'(irqreq), 16'd0);
    apb_read(8'h18, 8'h03, 1'b0, "err_irqstat_clr");
    apb_read(8'h00, 8'h55, 1'b0, "err_rd0");
    apb_read(8'h00, 8'h55, 1'b0, "err_rd1");

    // Glitch rejection and error responses
    rxd_drv = 1'b0; wait_cyc(4);
    rxd_drv = 1'b1; wait_cyc(100);
    apb_read(8'h04, 8'h05, 1'b0, "glitch_status");
    apb_read(8'h40, 8'h00, 1'b1, "unmapped_rd");
    apb_read(8'h00, 8'h00, 1'b1, "rx_empty_rd");
    apb_write(8'h04, 8'hFF, 1'b1, "status_wr");
    apb_read(8'h04, 8'h05, 1'b0, "status_after_wr");

    // Reset mid-frame
    apb_write(8'h08, 8'h03, 1'b0, "mid_ctrl");
    apb_write(8'h00, 8'h00, 1'b0, "mid_wr");
    wait_txd_low("mid");
    wait_cyc(30);
    check("mid_txd_low", 16'(txd), 16'd0);
    preset = 1'b1;
    wait_cyc(1);
    check("mid_rst_txd", 16'(txd), 16'd1);
    check("mid_rst_irq", 16'(irqreq), 16'd0);
    wait_cyc(2);
    preset = 1'b0;
    wait_cyc(1);
    apb_read(8'h04, 8'h05, 1'b0, "mid_status");
    apb_read(8'h08, 8'h03, 1'b0, "mid_ctrl_rd");
    apb_read(8'h0C, 8'h1A, 1'b0, "mid_divl");
    apb_read(8'h14, 8'h00, 1'b0, "mid_irqen");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
